// File: rtl/dds_sample_source_pkg.sv
// Shared constants for the DDS sample source: LFSR polynomial, sample and
// saturation widths, and the quarter-wave sine table generator.
package dds_sample_source_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int SAMPLE_W = 18;
  localparam int MAG_W    = 17;
  localparam int SUM_W    = 19;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 19'sd131071;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -19'sd131072;

  localparam int          LUT_PEAK  = 131071;
  localparam logic [63:0] PI_Q60    = 64'h3243_F6A8_885A_308D;
  localparam int          SIN_TERMS = 12;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s[0]) begin
      lfsr_next = (s >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_next = s >> 1;
    end
  endfunction

  // round(LUT_PEAK * sin(pi/2 * (idx + 0.5) / 2^aw)) via a Q60 Taylor series,
  // evaluated only at elaboration time to fill the ROM.
  function automatic logic [MAG_W-1:0] lut_entry(input int idx, input int aw);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc_pos;
    logic [127:0] acc_neg;
    logic [127:0] scaled;
    x       = ({64'd0, PI_Q60} * 128'(2 * idx + 1)) >> (aw + 2);
    x2      = (x * x) >> 60;
    term    = x;
    acc_pos = x;
    acc_neg = 128'd0;
    for (int k = 1; k <= SIN_TERMS; k++) begin
      term = ((term * x2) >> 60) / 128'(2 * k * (2 * k + 1));
      if ((k % 2) == 1) begin
        acc_neg = acc_neg + term;
      end else begin
        acc_pos = acc_pos + term;
      end
    end
    scaled    = (acc_pos - acc_neg) * 128'(LUT_PEAK) + (128'd1 << 59);
    lut_entry = MAG_W'(scaled >> 60);
  endfunction

endpackage

// File: rtl/quarter_sine_lut.sv
// Registered quarter-wave sine magnitude ROM: LUT_AW-bit address in,
// 17-bit unsigned magnitude out one cycle later.
module quarter_sine_lut
  import dds_sample_source_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LUT_AW-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [MAG_W-1:0] rom_s [DEPTH];
  logic [MAG_W-1:0] mag_q;
  logic [MAG_W-1:0] mag_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = lut_entry(i, LUT_AW);
    assign rom_s[i] = ENTRY;
  end

  always_comb begin
    mag_d = rom_s[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_q <= {MAG_W{1'b0}};
    end else begin
      mag_q <= mag_d;
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/dds_sample_source.sv
// Quarter-wave sine DDS sample source with amplitude shift and LFSR noise;
// emits an 18-bit signed sample with a one-cycle ready strobe every SAMPLE_DIV clocks.
module dds_sample_source
  import dds_sample_source_pkg::*;
#(
  parameter int SAMPLE_DIV = 50,
  parameter int PHASE_W    = 32,
  parameter int LUT_AW     = 8,
  parameter int NOISE_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [2:0]          amp_shift,
  input  logic                noise_en,
  output logic [SAMPLE_W-1:0] sample_sig,
  output logic                ready
);

  localparam int               DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam int               SNAP_W   = LUT_AW + 2;

  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0]        phase_acc_q, phase_acc_d;
  logic [SNAP_W-1:0]         phase_snap_q, phase_snap_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [2:0]                amp_q, amp_d;
  logic                      noise_en_q, noise_en_d;
  logic                      v1_q, v1_d;
  logic                      v2_q, v2_d;
  logic                      neg_q, neg_d;
  logic [SAMPLE_W-1:0]       sample_q, sample_d;
  logic                      ready_q, ready_d;

  logic                      tick_s;
  logic [LUT_AW-1:0]         idx_s;
  logic [LUT_AW-1:0]         lut_addr_s;
  logic [MAG_W-1:0]          lut_mag_s;
  logic signed [NOISE_W-1:0] noise_raw_s;
  logic signed [SUM_W-1:0]   mag_ext_s, signed_s, shifted_s, noise_s, sum_s;

  assign tick_s = en && (div_cnt_q == DIV_LAST);

  // Only the quadrant and table index survive the snapshot; finer phase bits are dropped.
  assign idx_s      = phase_snap_q[LUT_AW-1:0];
  assign lut_addr_s = phase_snap_q[SNAP_W-2] ? ~idx_s : idx_s;

  quarter_sine_lut #(
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (lut_addr_s),
    .mag   (lut_mag_s)
  );

  always_comb begin
    div_cnt_d    = div_cnt_q;
    phase_acc_d  = phase_acc_q;
    phase_snap_d = phase_snap_q;
    lfsr_d       = lfsr_q;
    amp_d        = amp_q;
    noise_en_d   = noise_en_q;
    neg_d        = neg_q;
    v1_d         = tick_s;
    v2_d         = v1_q;
    ready_d      = v2_q;

    if (en) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? {DIV_W{1'b0}} : div_cnt_q + DIV_W'(1'b1);
    end else begin
      div_cnt_d = div_cnt_q;
    end

    if (tick_s) begin
      phase_snap_d = phase_acc_q[PHASE_W-1 -: SNAP_W];
      phase_acc_d  = phase_acc_q + phase_inc;
      lfsr_d       = lfsr_next(lfsr_q);
      amp_d        = amp_shift;
      noise_en_d   = noise_en;
    end else begin
      phase_snap_d = phase_snap_q;
    end

    if (v1_q) begin
      neg_d = phase_snap_q[SNAP_W-1];
    end else begin
      neg_d = neg_q;
    end

    // Stage-0 captures stay stable until stage 2 because ticks are >= 4 cycles apart.
    mag_ext_s   = {{(SUM_W - MAG_W){1'b0}}, lut_mag_s};
    signed_s    = neg_q ? -mag_ext_s : mag_ext_s;
    shifted_s   = signed_s >>> amp_q;
    noise_raw_s = lfsr_q[NOISE_W-1:0];
    if (noise_en_q) begin
      noise_s = SUM_W'(noise_raw_s);
    end else begin
      noise_s = {SUM_W{1'b0}};
    end
    sum_s = shifted_s + noise_s;

    if (!v2_q) begin
      sample_d = sample_q;
    end else if (sum_s > SAT_MAX) begin
      sample_d = SAT_MAX[SAMPLE_W-1:0];
    end else if (sum_s < SAT_MIN) begin
      sample_d = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sample_d = sum_s[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= {DIV_W{1'b0}};
      phase_acc_q  <= {PHASE_W{1'b0}};
      phase_snap_q <= {SNAP_W{1'b0}};
      lfsr_q       <= LFSR_SEED;
      amp_q        <= 3'd0;
      noise_en_q   <= 1'b0;
      neg_q        <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      sample_q     <= {SAMPLE_W{1'b0}};
      ready_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      phase_acc_q  <= phase_acc_d;
      phase_snap_q <= phase_snap_d;
      lfsr_q       <= lfsr_d;
      amp_q        <= amp_d;
      noise_en_q   <= noise_en_d;
      neg_q        <= neg_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      sample_q     <= sample_d;
      ready_q      <= ready_d;
    end
  end

  assign sample_sig = sample_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_dds_sample_source.sv
// Directed and randomized stimulus for dds_sample_source, checked every cycle
// against a sine/LFSR reference model built from real-valued trigonometry.
module tb_dds_sample_source;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] phase_inc;
  logic [2:0]  amp_shift;
  logic        noise_en;
  logic [17:0] sample_sig;
  logic        ready;

  dds_sample_source #(
    .SAMPLE_DIV (DIV),
    .PHASE_W    (32),
    .LUT_AW     (8),
    .NOISE_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .phase_inc  (phase_inc),
    .amp_shift  (amp_shift),
    .noise_en   (noise_en),
    .sample_sig (sample_sig),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int          cyc = 0;
  int          m_en_cycles = 0;
  logic [31:0] m_phase = 32'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          due_q[$];
  int          val_q[$];
  int          exp_sample = 0;
  logic        exp_ready = 1'b0;
  bit          m_ticked = 1'b0;

  function automatic int lut_ref(input int a);
    return $rtoi($floor(131071.0 * $sin(3.141592653589793 * (real'(a) + 0.5) / 512.0) + 0.5));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int sample_ref(input logic [31:0] ph, input int amp, input bit nz,
                                    input logic [15:0] lf);
    int quad, idx, a, v, noise;
    quad = int'(ph[31:30]);
    idx  = int'(ph[29:22]);
    a    = ((quad % 2) == 1) ? 255 - idx : idx;
    v    = lut_ref(a);
    if (quad >= 2) v = -v;
    v = $rtoi($floor(real'(v) / real'(1 << amp)));
    noise = int'(lf[7:0]);
    if (noise >= 128) noise = noise - 256;
    if (nz) v = v + noise;
    if (v > 131071) v = 131071;
    if (v < -131072) v = -131072;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] req);
    n_checks++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, req);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic cycle();
    bit tick;
    tick = 1'b0;
    if (!rst_n) begin
      m_en_cycles = 0;
      m_phase     = 32'd0;
      m_lfsr      = 16'hACE1;
      due_q.delete();
      val_q.delete();
      exp_sample  = 0;
    end else if (en) begin
      tick = ((m_en_cycles % DIV) == DIV - 1);
      m_en_cycles++;
      if (tick) begin
        m_lfsr = lfsr_step(m_lfsr);
        due_q.push_back(cyc + 3);
        val_q.push_back(sample_ref(m_phase, int'(amp_shift), noise_en, m_lfsr));
        m_phase = m_phase + phase_inc;
      end
    end
    m_ticked = tick;
    @(posedge clk);
    #1;
    cyc++;
    exp_ready = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_ready  = 1'b1;
      exp_sample = val_q.pop_front();
      void'(due_q.pop_front());
    end
    check("ready", 32'(ready), 32'(exp_ready));
    check("sample_sig", 32'($signed(sample_sig)), exp_sample);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < 2 * DIV; i++) begin
      cycle();
      if (m_ticked) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; phase_inc = 32'd0; amp_shift = 3'd0; noise_en = 1'b0;
    run(3);

    // Constant phase: every sample is lut[0]
    rst_n = 1'b1; en = 1'b1;
    run(20);

    // Quarter-turn steps: the four quadrant extremes
    phase_inc = 32'h4000_0000;
    run(20);
    amp_shift = 3'd1;
    run(20);

    // Noise from reset, including positive saturation on the second sample
    rst_n = 1'b0; amp_shift = 3'd0; noise_en = 1'b1;
    run(2);
    rst_n = 1'b1;
    run(14);

    // Negative saturation: third sample is -131070 with noise -100
    rst_n = 1'b0; phase_inc = 32'h6000_0000;
    run(2);
    rst_n = 1'b1;
    run(16);

    // en dropped the cycle after a tick, then resumed
    phase_inc = 32'h4000_0000; noise_en = 1'b0;
    run_to_tick();
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(14);

    // Reset in the cycle after a tick discards the in-flight sample
    noise_en = 1'b1;
    run_to_tick();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(14);

    // Randomized tuning words, shifts, noise and enable gaps
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      phase_inc = $urandom;
      amp_shift = 3'($urandom_range(0, 7));
      noise_en  = 1'($urandom_range(0, 1));
      cycle();
    end
    en = 1'b1;
    run(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dds_sample_source.md
Name: dds_sample_source

Overview:
Transmit-side sample source for the fir_filter input interface: produces a signed 18-bit sample plus a 1-cycle ready strobe at a programmable sample rate. Samples come from a quarter-wave sine DDS with optional amplitude scaling and LFSR noise injection. Its outputs connect directly to fir_filter input_sig/ready, for on-chip filter bring-up and stimulus.

Parameters:
SAMPLE_DIV, 50, clk cycles per output sample; legal range >= 4.
PHASE_W, 32, phase accumulator width.
LUT_AW, 8, quarter-wave table address width (256 entries).
NOISE_W, 8, width of signed noise term taken from LFSR.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
en  in  1  run enable
phase_inc  in  PHASE_W  frequency tuning word, sampled on each tick
amp_shift  in  3  arithmetic right shift applied to sine (0..7)
noise_en  in  1  add LFSR noise when high, sampled on each tick
sample_sig  out  18  signed sample, held between updates
ready  out  1  one-cycle strobe, sample_sig valid in that cycle

Behaviour:
- Reset (rst_n=0 at edge): div_cnt=0, phase_acc=0, lfsr=16'hACE1, pipeline valids=0, sample_sig=0, ready=0. Reset mid-pipeline discards in-flight samples; no ready follows.
- Divider: while en=1, div_cnt counts 0..SAMPLE_DIV-1 and wraps; tick = (en && div_cnt==SAMPLE_DIV-1). en=0: div_cnt holds, no ticks. First tick occurs SAMPLE_DIV cycles after en first sampled high from reset.
- Stage 0 (tick cycle T): phase_snap <= phase_acc (pre-increment); phase_acc <= phase_acc + phase_inc (mod 2^PHASE_W); lfsr advances one step; amp_shift and noise_en captured; v1<=1.
- Stage 1 (T+1): quadrant q = phase_snap[PHASE_W-1:PHASE_W-2], idx = next LUT_AW bits; address = idx for q0/q2, ~idx for q1/q3; registered LUT read; v2<=1.
- Stage 2 (T+2): value = +lut for q0/q1, -lut for q2/q3; >>> amp_shift; + sign-extended lfsr[NOISE_W-1:0] if noise_en; saturate to [-131072, 131071]; register into sample_sig; ready<=1.
- ready high during cycle T+3 only; fixed latency 3 cycles from tick. Samples spaced exactly SAMPLE_DIV cycles while en=1.
- en dropping after a tick: in-flight sample still completes and strobes ready.
- LUT: lut[i] = round(131071*sin(pi/2*(i+0.5)/2^LUT_AW)), unsigned 17-bit; lut[0]=402, lut[255]=131070.
- LFSR: 16-bit Galois, right shift; if lsb=1 then (s>>1)^16'hB400 else s>>1. Noise uses post-advance value.
- Arithmetic: internal sum at least 19 bits signed before saturation; no wrap permitted.
- phase_inc/amp_shift/noise_en changes outside tick have no effect until the next tick.

Decomposition:
- Shared package/include: LFSR seed 16'hACE1, tap mask 16'hB400, sample width 18, saturation limits, LUT generation constants.
- One sub-module: quarter_sine_lut (registered read, LUT_AW address -> 17-bit magnitude, contents from the shared constants).

Test Plan:
- Reset then en=1, SAMPLE_DIV=4, phase_inc=0, amp_shift=0, noise_en=0 -> first ready 7 cycles after en, then every 4 cycles; sample_sig=402 each time.
- phase_inc=32'h4000_0000 -> successive samples 402, 131070, -402, -131070, repeating.
- Same as previous with amp_shift=1 -> 201, 65535, -201, -65535.
- noise_en=1, phase_inc=32'h4000_0000 from reset -> first sample 402+112=514 (lfsr 16'hE270); second 131070+56 saturates to 131071 (lfsr 16'h7138).
- en dropped 1 cycle after a tick -> that sample's ready still occurs at T+3; no further ready; div_cnt frozen; re-raising en resumes at the frozen count.
- rst_n asserted in cycle T+1 of a sample -> no ready, sample_sig=0, phase_acc=0, lfsr=16'hACE1 after release.
